// File: rtl/input_test_pkg.sv
// Shared types and layout constants for the controller snapshot scheduler.
`timescale 1ns/1ps
package input_test_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} sched_state_t;

  localparam int SLOT_STRIDE = 8;
  localparam int PAD_BYTES   = 6;
  localparam int FRAME_BYTES = 2;

endpackage

// File: rtl/input_snapshot_sched.sv
// Copies a per-VBlank snapshot of all pads into the input-mirror RAM, yielding the port to ioctl downloads.
// Optional build macro INPUT_SKIP_UNCHANGED_EN skips pad bytes identical to the last value written.
`timescale 1ns/1ps
module input_snapshot_sched
  import input_test_pkg::*;
#(
  parameter int                NUM_PADS  = 6,
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h3F00
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    vblank,
  input  logic [32*NUM_PADS-1:0]  joystick,
  input  logic [16*NUM_PADS-1:0]  analog,
  input  logic                    dn_wr,
  input  logic [ADDR_W-1:0]       dn_addr,
  input  logic [7:0]              dn_data,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [7:0]              ram_data,
  output logic                    busy,
  output logic                    overrun,
  output logic [15:0]             frame_cnt
);

  localparam int PAD_TOTAL = PAD_BYTES * NUM_PADS;
  localparam int TOTAL     = PAD_TOTAL + FRAME_BYTES;
  localparam int IDX_W     = $clog2(TOTAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  sched_state_t state_q, state_d;
  logic vblank_q, vb_edge;
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [32*NUM_PADS-1:0] joy_q, joy_d;
  logic [16*NUM_PADS-1:0] ana_q, ana_d;
  logic [IDX_W-1:0] idx_q, idx_d, cur;
  logic ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0] ram_data_q, ram_data_d;
  logic scan_wr;

  logic [7:0]        byte_arr [TOTAL];
  logic [ADDR_W-1:0] addr_arr [TOTAL];

  assign vb_edge = vblank & ~vblank_q;
  assign scan_wr = (state_q == WRITE) && !dn_wr;

  // Flat byte/address tables indexed by scan position i = 6p+k, then the two frame bytes.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      for (genvar gk = 0; gk < PAD_BYTES; gk++) begin : g_byte
        assign addr_arr[gi*PAD_BYTES+gk] = ADDR_W'(BASE_ADDR + SLOT_STRIDE*gi + gk);
        if (gk < 4) begin : g_joy
          assign byte_arr[gi*PAD_BYTES+gk] = joy_q[32*gi+8*gk +: 8];
        end else begin : g_ana
          assign byte_arr[gi*PAD_BYTES+gk] = ana_q[16*gi+8*(gk-4) +: 8];
        end
      end
    end
    for (gi = 0; gi < FRAME_BYTES; gi++) begin : g_frm
      assign addr_arr[PAD_TOTAL+gi] = ADDR_W'(BASE_ADDR + SLOT_STRIDE*NUM_PADS + gi);
      assign byte_arr[PAD_TOTAL+gi] = frame_cnt_q[8*gi +: 8];
    end
  endgenerate

`ifdef INPUT_SKIP_UNCHANGED_EN
  logic [8*PAD_TOTAL-1:0] last_q, last_d;
  logic [TOTAL-1:0]       need;

  generate
    for (gi = 0; gi < PAD_TOTAL; gi++) begin : g_need
      assign need[gi] = byte_arr[gi] != last_q[8*gi +: 8];
    end
    for (gi = 0; gi < FRAME_BYTES; gi++) begin : g_need_frm
      assign need[PAD_TOTAL+gi] = 1'b1;
    end
  endgenerate

  // Lowest needed index at or after idx_q; frame bytes guarantee a hit.
  always_comb begin
    cur = LAST_IDX;
    for (int i = TOTAL - 1; i >= 0; i--) begin
      if (need[i] && IDX_W'(i) >= idx_q) cur = IDX_W'(i);
    end
  end

  always_comb begin
    last_d = last_q;
    for (int i = 0; i < PAD_TOTAL; i++) begin
      if (scan_wr && cur == IDX_W'(i)) last_d[8*i +: 8] = byte_arr[i];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) last_q <= '0;
    else       last_q <= last_d;
  end
`else
  assign cur = idx_q;
`endif

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    joy_d       = joy_q;
    ana_d       = ana_q;
    idx_d       = idx_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;

    if (dn_wr) begin
      ram_we_d   = 1'b1;
      ram_addr_d = dn_addr;
      ram_data_d = dn_data;
    end else if (scan_wr) begin
      ram_we_d   = 1'b1;
      ram_addr_d = addr_arr[cur];
      ram_data_d = byte_arr[cur];
    end

    if (vb_edge && state_q != IDLE) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      IDLE: if (vb_edge) state_d = CAPTURE;
      CAPTURE: begin
        joy_d       = joystick;
        ana_d       = analog;
        frame_cnt_d = frame_cnt_q + 16'd1;
        idx_d       = '0;
        state_d     = WRITE;
      end
      WRITE: begin
        if (scan_wr) begin
          if (cur == LAST_IDX) state_d = DONE;
          else                 idx_d   = cur + 1'b1;
        end
      end
      DONE: begin
        // An edge landing exactly here is served now rather than parked.
        if (pending_q || vb_edge) begin
          state_d   = CAPTURE;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      vblank_q    <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      joy_q       <= '0;
      ana_q       <= '0;
      idx_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      vblank_q    <= vblank;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      joy_q       <= joy_d;
      ana_q       <= ana_d;
      idx_q       <= idx_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_input_snapshot_sched.sv
// Directed bench for input_snapshot_sched: logs every RAM write and compares against hand-computed bytes.
`timescale 1ns/1ps
module tb_input_snapshot_sched;

  logic         clk_sys = 1'b0;
  logic         reset;
  logic         vblank;
  logic [191:0] joystick;
  logic [95:0]  analog;
  logic         dn_wr;
  logic [13:0]  dn_addr;
  logic [7:0]   dn_data;
  logic         ram_we;
  logic [13:0]  ram_addr;
  logic [7:0]   ram_data;
  logic         busy;
  logic         overrun;
  logic [15:0]  frame_cnt;

  input_snapshot_sched dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .vblank    (vblank),
    .joystick  (joystick),
    .analog    (analog),
    .dn_wr     (dn_wr),
    .dn_addr   (dn_addr),
    .dn_data   (dn_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .busy      (busy),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt = 0;
  int cyc      = 0;
  int base     = 0;
  int t0       = 0;
  logic [13:0] wa [$];
  logic [7:0]  wd [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s ok (%0h)", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: outputs are sampled at the falling edge, inputs may be changed afterwards.
  task automatic tick();
    @(negedge clk_sys);
    cyc++;
    if (ram_we) begin
      wa.push_back(ram_addr);
      wd.push_back(ram_data);
    end
    if (busy) busy_cnt++;
  endtask

  task automatic vb_pulse();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [13:0] a, input logic [7:0] d);
    logic [21:0] got;
    got = (idx < wa.size()) ? {wa[idx], wd[idx]} : 22'h3FFFFF;
    check(tag, {10'd0, got}, {10'd0, a, d});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    vblank   = 1'b0;
    joystick = '0;
    analog   = '0;
    dn_wr    = 1'b0;
    dn_addr  = '0;
    dn_data  = '0;
    repeat (3) tick();
    check("rst_we",      {31'd0, ram_we}, 32'd0);
    check("rst_addr",    {18'd0, ram_addr}, 32'd0);
    check("rst_data",    {24'd0, ram_data}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_frame",   {16'd0, frame_cnt}, 32'd0);
    reset = 1'b0;
    tick();

    // Idle passthrough of the download port
    dn_wr = 1'b1; dn_addr = 14'h0123; dn_data = 8'h5C;
    tick();
    check("pass_we", {31'd0, ram_we}, 32'd1);
    check("pass_ad", {10'd0, ram_addr, ram_data}, {10'd0, 14'h0123, 8'h5C});
    dn_wr = 1'b0;
    tick();
    check("pass_we_off", {31'd0, ram_we}, 32'd0);

`ifndef INPUT_SKIP_UNCHANGED_EN
    // Test 1: basic scan, first and last pad, frame bytes
    joystick[31:0]    = 32'h11223344;
    analog[15:0]      = 16'hA55A;
    joystick[191:160] = 32'h0A0B0C0D;
    analog[95:80]     = 16'h7788;
    busy_cnt = 0; base = wa.size();
    vb_pulse();
    wait_idle("t1_idle", 200);
    check("t1_count", wa.size() - base, 38);
    chk_wr("t1_b0", base+0, 14'h3F00, 8'h44);
    chk_wr("t1_b1", base+1, 14'h3F01, 8'h33);
    chk_wr("t1_b2", base+2, 14'h3F02, 8'h22);
    chk_wr("t1_b3", base+3, 14'h3F03, 8'h11);
    chk_wr("t1_b4", base+4, 14'h3F04, 8'h5A);
    chk_wr("t1_b5", base+5, 14'h3F05, 8'hA5);
    chk_wr("t1_p1", base+6, 14'h3F08, 8'h00);
    chk_wr("t1_p5j0", base+30, 14'h3F28, 8'h0D);
    chk_wr("t1_p5j3", base+33, 14'h3F2B, 8'h0A);
    chk_wr("t1_p5a0", base+34, 14'h3F2C, 8'h88);
    chk_wr("t1_p5a1", base+35, 14'h3F2D, 8'h77);
    chk_wr("t1_flo", base+36, 14'h3F30, 8'h01);
    chk_wr("t1_fhi", base+37, 14'h3F31, 8'h00);
    check("t1_busy", busy_cnt, 40);
    check("t1_frame", {16'd0, frame_cnt}, 32'd1);

    // Test 2: 3-cycle download burst landing on scan byte 5
    busy_cnt = 0; base = wa.size();
    vb_pulse();
    repeat (6) tick();
    dn_wr = 1'b1;
    for (int j = 0; j < 3; j++) begin
      dn_addr = 14'h0100 + 14'(j);
      dn_data = 8'hD0 + 8'(j);
      tick();
    end
    dn_wr = 1'b0;
    wait_idle("t2_idle", 200);
    check("t2_count", wa.size() - base, 41);
    chk_wr("t2_b4", base+4, 14'h3F04, 8'h5A);
    chk_wr("t2_dn0", base+5, 14'h0100, 8'hD0);
    chk_wr("t2_dn1", base+6, 14'h0101, 8'hD1);
    chk_wr("t2_dn2", base+7, 14'h0102, 8'hD2);
    chk_wr("t2_b5", base+8, 14'h3F05, 8'hA5);
    chk_wr("t2_b6", base+9, 14'h3F08, 8'h00);
    chk_wr("t2_flo", base+39, 14'h3F30, 8'h02);
    chk_wr("t2_fhi", base+40, 14'h3F31, 8'h00);
    check("t2_busy", busy_cnt, 43);

    // Test 3: pending edge, back-to-back scans, overrun
    do_reset();
    check("t3_frame0", {16'd0, frame_cnt}, 32'd0);
    busy_cnt = 0; base = wa.size(); t0 = cyc;
    vb_pulse();
    repeat (10) tick();
    vb_pulse();
    check("t3_no_ovr1", {31'd0, overrun}, 32'd0);
    begin
      int n = 0;
      while (frame_cnt != 16'd2 && n < 100) begin
        tick();
        n++;
      end
    end
    check("t3_frame2", {16'd0, frame_cnt}, 32'd2);
    check("t3_f2_time", cyc - t0, 42);
    repeat (5) tick();
    vb_pulse();
    check("t3_no_ovr2", {31'd0, overrun}, 32'd0);
    repeat (3) tick();
    vb_pulse();
    tick();
    check("t3_ovr", {31'd0, overrun}, 32'd1);
    wait_idle("t3_idle", 300);
    check("t3_count", wa.size() - base, 114);
    check("t3_busy", busy_cnt, 120);
    chk_wr("t3_f1", base+36, 14'h3F30, 8'h01);
    chk_wr("t3_f2", base+74, 14'h3F30, 8'h02);
    chk_wr("t3_f3", base+112, 14'h3F30, 8'h03);
    check("t3_ovr_sticky", {31'd0, overrun}, 32'd1);

    // Test 4: inputs changing right after CAPTURE are not seen
    do_reset();
    check("t4_ovr_clr", {31'd0, overrun}, 32'd0);
    joystick[31:0] = 32'hCAFEBABE;
    analog[15:0]   = 16'h0F0E;
    base = wa.size();
    vb_pulse();
    tick();
    joystick[31:0] = 32'hDEADBEEF;
    analog[15:0]   = 16'h1234;
    wait_idle("t4_idle", 200);
    chk_wr("t4_b0", base+0, 14'h3F00, 8'hBE);
    chk_wr("t4_b1", base+1, 14'h3F01, 8'hBA);
    chk_wr("t4_b2", base+2, 14'h3F02, 8'hFE);
    chk_wr("t4_b3", base+3, 14'h3F03, 8'hCA);
    chk_wr("t4_b4", base+4, 14'h3F04, 8'h0E);
    chk_wr("t4_b5", base+5, 14'h3F05, 8'h0F);

    // Test 5: reset in mid-scan aborts, next frame restarts cleanly
    vb_pulse();
    repeat (20) tick();
    reset = 1'b1;
    #1;
    check("t5_we", {31'd0, ram_we}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_frame", {16'd0, frame_cnt}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    base = wa.size();
    vb_pulse();
    wait_idle("t5_idle", 200);
    check("t5_count", wa.size() - base, 38);
    chk_wr("t5_b0", base+0, 14'h3F00, 8'hEF);
    chk_wr("t5_flo", base+36, 14'h3F30, 8'h01);
    chk_wr("t5_fhi", base+37, 14'h3F31, 8'h00);
`else
    // Test 6: unchanged pad bytes are skipped
    joystick[31:0] = 32'h11223344;
    analog[15:0]   = 16'hA55A;
    base = wa.size();
    vb_pulse();
    wait_idle("t6_idle1", 200);
    check("t6_count1", wa.size() - base, 8);
    chk_wr("t6_b0", base+0, 14'h3F00, 8'h44);
    chk_wr("t6_b5", base+5, 14'h3F05, 8'hA5);
    chk_wr("t6_f1", base+6, 14'h3F30, 8'h01);
    busy_cnt = 0; base = wa.size();
    vb_pulse();
    wait_idle("t6_idle2", 200);
    check("t6_count2", wa.size() - base, 2);
    chk_wr("t6_flo", base+0, 14'h3F30, 8'h02);
    chk_wr("t6_fhi", base+1, 14'h3F31, 8'h00);
    check("t6_busy", busy_cnt, 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
